// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding load/store responder for the core's
// data port. Requests are accepted over a valid/ready handshake, the access is
// performed after a programmable latency, and the response is held until the
// requester takes it. Backing store is a word-addressed 64-bit RAM indexed by
// byte address; misaligned or out-of-range accesses return an error.
module data_mem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Full 64-bit limit so any upper address bit produces an error, never an alias.
  localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH) << 3;
  // Counter starts at LATENCY-1 so the access edge lands LATENCY edges after accept.
  localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // RAM is not affected by rst; it only starts out zeroed.
  logic [63:0] mem_q [DEPTH] = '{default: '0};

  logic             access;
  logic             acc_err;
  logic [IDX_W-1:0] acc_idx;
  logic             mem_we;

  // Decode of the latched request for the access edge (last BUSY cycle).
  always_comb begin
    access  = (state_q == S_BUSY) && (cnt_q == '0);
    acc_err = (addr_q[2:0] != 3'b000) || (addr_q >= ADDR_LIMIT);
    acc_idx = addr_q[3 +: IDX_W];
    // rst wins over a store that would commit on this same edge.
    mem_we  = access && write_q && !acc_err && !rst;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM write port: commits a good store at the BUSY->RESP edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[acc_idx] <= wdata_q;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (req_valid)     state_d = S_BUSY;
      S_BUSY: if (cnt_q == '0)   state_d = S_RESP;
      S_RESP: if (resp_ready)    state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  // Datapath next values: latch on accept, count down, access, clear on handshake.
  always_comb begin
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CNT_INIT;
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          err_d   = acc_err;
          rdata_d = (!acc_err && !write_q) ? mem_q[acc_idx] : '0;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Output decode.
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    resp_rdata = rdata_q;
    resp_err   = err_q;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: a LATENCY=2 instance for the
// main scenarios and a LATENCY=1 instance for the back-to-back stream.
module tb_data_mem_responder;

  localparam int DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err;
  logic [63:0] req_addr, req_wdata, resp_rdata;

  logic        b_req_valid, b_req_ready, b_req_write, b_resp_valid, b_resp_ready, b_resp_err;
  logic [63:0] b_req_addr, b_req_wdata, b_resp_rdata;

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  int checks   = 0;
  int failures = 0;

  // Scoreboard entry: {rdata, err}
  logic [64:0] exp_q[$];
  logic [63:0] model [DEPTH];

  function automatic logic addr_bad(input logic [63:0] a);
    return (a[2:0] != 3'b000) || (a >= 64'(8 * DEPTH));
  endfunction

  function automatic void expect_resp(input logic w, input logic [63:0] a, input logic [63:0] d);
    if (addr_bad(a)) exp_q.push_back({64'd0, 1'b1});
    else if (w) begin
      model[int'(a >> 3)] = d;
      exp_q.push_back({64'd0, 1'b0});
    end else exp_q.push_back({model[int'(a >> 3)], 1'b0});
  endfunction

  task automatic issue(input logic w, input logic [63:0] a, input logic [63:0] d, output bit ok);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    ok = req_ready;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int cyc);
    cyc = 0;
    while (!resp_valid && cyc < 50) begin @(negedge clk); cyc++; end
  endtask

  task automatic handshake;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  // Full transaction: issue, push expectation, wait, sample, pop, handshake.
  task automatic xact(input logic w, input logic [63:0] a, input logic [63:0] d,
                      output logic [63:0] rd, output logic er, output int cyc,
                      output logic [64:0] ex, output bit ok);
    issue(w, a, d, ok);
    expect_resp(w, a, d);
    wait_resp(cyc);
    ok = ok && resp_valid;
    rd = resp_rdata;
    er = resp_err;
    ex = exp_q.pop_front();
    if (resp_valid) handshake();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({req_ready, resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 1'b0, 64'd0}) begin
      failures++;
      $display("FAIL reset: ready=%b valid=%b err=%b rdata=%h, required 1 0 0 0",
               req_ready, resp_valid, resp_err, resp_rdata);
    end
    checks++;
    if ({b_req_ready, b_resp_valid, b_resp_err, b_resp_rdata} !== {1'b1, 1'b0, 1'b0, 64'd0}) begin
      failures++;
      $display("FAIL reset_l1: ready=%b valid=%b err=%b rdata=%h, required 1 0 0 0",
               b_req_ready, b_resp_valid, b_resp_err, b_resp_rdata);
    end
  endtask

  task automatic test_store_load;
    logic [63:0] rd; logic er; int cyc; logic [64:0] ex; bit ok;
    xact(1'b1, 64'h10, 64'hDEADBEEF_01234567, rd, er, cyc, ex, ok);
    checks++;
    if (!ok || cyc != 2 || rd !== ex[64:1] || er !== ex[0]) begin
      failures++;
      $display("FAIL store_lat: ok=%0d cyc=%0d rdata=%h err=%b, required cyc=2 rdata=%h err=%b",
               ok, cyc, rd, er, ex[64:1], ex[0]);
    end
    xact(1'b0, 64'h10, '0, rd, er, cyc, ex, ok);
    checks++;
    if (!ok || cyc != 2 || rd !== ex[64:1] || er !== ex[0]) begin
      failures++;
      $display("FAIL load_back: ok=%0d cyc=%0d rdata=%h err=%b, required cyc=2 rdata=%h err=%b",
               ok, cyc, rd, er, ex[64:1], ex[0]);
    end
  endtask

  task automatic test_errors;
    logic [63:0] rd; logic er; int cyc; logic [64:0] ex; bit ok;
    logic        ws [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [63:0] as [8] = '{64'h13, 64'h800, 64'h0, 64'h8000_0000_0000_0010,
                            64'h10, 64'h7F8, 64'h7F8, 64'h7FC};
    logic [63:0] ds [8] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h1111_2222_3333_4444,
                            64'h0, 64'hA5A5_0000_5A5A_FFFF, 64'h0, 64'h9999};
    for (int i = 0; i < 8; i++) begin
      xact(ws[i], as[i], ds[i], rd, er, cyc, ex, ok);
      checks++;
      if (!ok || rd !== ex[64:1] || er !== ex[0]) begin
        failures++;
        $display("FAIL err_case%0d addr=%h: ok=%0d rdata=%h err=%b, required rdata=%h err=%b",
                 i, as[i], ok, rd, er, ex[64:1], ex[0]);
      end
    end
  endtask

  task automatic test_hold;
    logic [63:0] r0; logic e0; int cyc; logic [64:0] ex; bit ok;
    logic [63:0] rd; logic er;
    issue(1'b0, 64'h10, '0, ok);
    expect_resp(1'b0, 64'h10, '0);
    wait_resp(cyc);
    ex = exp_q.pop_front();
    r0 = resp_rdata; e0 = resp_err;
    checks++;
    if (!ok || !resp_valid || r0 !== ex[64:1] || e0 !== ex[0]) begin
      failures++;
      $display("FAIL hold_first: ok=%0d valid=%b rdata=%h err=%b, required rdata=%h err=%b",
               ok, resp_valid, r0, e0, ex[64:1], ex[0]);
    end
    // A store offered while in RESP must be ignored.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h10; req_wdata = 64'hBAD0_BAD0_BAD0_BAD0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== ex[64:1] || resp_err !== ex[0] || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_cyc%0d: valid=%b rdata=%h err=%b ready=%b, required 1 %h %b 0",
                 i, resp_valid, resp_rdata, resp_err, req_ready, ex[64:1], ex[0]);
      end
    end
    // Handshake with a new request presented in the same cycle.
    req_addr = 64'h18; req_wdata = 64'h7777;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b0;
    checks++;
    if ({resp_valid, resp_err, resp_rdata, req_ready} !== {1'b0, 1'b0, 64'd0, 1'b1}) begin
      failures++;
      $display("FAIL hold_release: valid=%b err=%b rdata=%h ready=%b, required 0 0 0 1",
               resp_valid, resp_err, resp_rdata, req_ready);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL same_cycle_accept: ready=%b valid=%b, required 1 0", req_ready, resp_valid);
    end
    xact(1'b0, 64'h18, '0, rd, er, cyc, ex, ok);
    checks++;
    if (!ok || rd !== ex[64:1] || er !== ex[0]) begin
      failures++;
      $display("FAIL no_store_18: rdata=%h err=%b, required %h %b", rd, er, ex[64:1], ex[0]);
    end
    xact(1'b0, 64'h10, '0, rd, er, cyc, ex, ok);
    checks++;
    if (!ok || rd !== ex[64:1] || er !== ex[0]) begin
      failures++;
      $display("FAIL no_store_10: rdata=%h err=%b, required %h %b", rd, er, ex[64:1], ex[0]);
    end
  endtask

  task automatic test_reset_busy;
    logic [63:0] rd; logic er; int cyc; logic [64:0] ex; bit ok;
    bit seen_valid = 0;
    issue(1'b1, 64'h20, 64'h55, ok);   // accepted; now in BUSY with a count pending
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (!ok || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_busy: ok=%0d ready=%b valid=%b, required 1 0", ok, req_ready, resp_valid);
    end
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) seen_valid = 1;
    end
    checks++;
    if (seen_valid) begin
      failures++;
      $display("FAIL rst_drop: resp_valid=1 after reset, required 0");
    end
    xact(1'b0, 64'h20, '0, rd, er, cyc, ex, ok);
    checks++;
    if (!ok || rd !== ex[64:1] || er !== ex[0]) begin
      failures++;
      $display("FAIL rst_no_commit: rdata=%h err=%b, required %h %b", rd, er, ex[64:1], ex[0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [64:0] q1[$];
    logic [63:0] m1 [DEPTH];
    int t_resp[$];
    int issued = 0;
    int got = 0;
    logic [64:0] ex;
    logic [63:0] a, d;
    for (int i = 0; i < DEPTH; i++) m1[i] = '0;
    b_resp_ready = 1'b1;
    for (int c = 0; c < 200 && got < 8; c++) begin
      @(negedge clk);
      if (b_resp_valid) begin
        ex = q1.pop_front();
        checks++;
        if (b_resp_rdata !== ex[64:1] || b_resp_err !== ex[0]) begin
          failures++;
          $display("FAIL b2b_data%0d: rdata=%h err=%b, required %h %b",
                   got, b_resp_rdata, b_resp_err, ex[64:1], ex[0]);
        end
        if (got >= 4) t_resp.push_back(c);
        got++;
      end
      if (b_req_ready && issued < 8) begin
        a = 64'h40 + 64'(8 * (issued % 4));
        d = {32'hC0DE_0000 + 32'(issued), 32'(issued * 977 + 3)};
        b_req_valid = 1'b1;
        b_req_write = (issued < 4);
        b_req_addr  = a;
        b_req_wdata = d;
        if (issued < 4) begin
          m1[int'(a >> 3)] = d;
          q1.push_back({64'd0, 1'b0});
        end else q1.push_back({m1[int'(a >> 3)], 1'b0});
        issued++;
      end else if (issued >= 8) b_req_valid = 1'b0;
    end
    b_req_valid = 1'b0;
    b_resp_ready = 1'b0;
    checks++;
    if (got != 8) begin
      failures++;
      $display("FAIL b2b_count: responses=%0d, required 8", got);
    end
    for (int i = 1; i < t_resp.size(); i++) begin
      checks++;
      if (t_resp[i] - t_resp[i-1] != 3) begin
        failures++;
        $display("FAIL b2b_spacing%0d: gap=%0d cycles, required 3", i, t_resp[i] - t_resp[i-1]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    test_reset();
    test_store_load();
    test_errors();
    test_hold();
    test_reset_busy();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
